instr_fetch_unit: RTL and testbench

Instruction-fetch sequencer between the Avalon-MM instruction memory port and the instruction register stage. Owns the program counter and issues word reads that are held stable across `avm_waitrequest`. Delivers each fetched word with a one-cycle valid strobe and a matching PC. Applies branch/jump redirects with MIPS delay-slot ordering, and halts the CPU when execution reaches address 0.

---
 rtl/instr_fetch_unit.sv | 107 ++++++++++
 tb/tb_instr_fetch_unit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch sequencer: owns the PC, issues Avalon-MM word reads, delivers each word with
// its PC, applies delay-slot redirects and halts when fetch reaches HALT_ADDR.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000,
  parameter logic [31:0] HALT_ADDR    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic        pc_load,
  input  logic [31:0] pc_target,
  output logic [31:0] avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic [31:0] instr_out,
  output logic        instr_valid,
  output logic [31:0] instr_pc,
  output logic        delay_out,
  output logic        halted
);

  typedef enum logic [1:0] {StIdle, StRead, StHalt} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] redir_tgt_q;
  logic        redir_pend_q;
  logic [31:0] instr_out_q;
  logic [31:0] instr_pc_q;
  logic        instr_valid_q;
  logic        halted_q;

  logic [31:0] tgt_aligned;
  logic [31:0] next_pc;

  assign tgt_aligned = pc_target & 32'hFFFF_FFFC;

  // A same-cycle redirect beats a pending one; otherwise fall through sequentially.
  always_comb begin
    next_pc = pc_q + 32'd4;
    if (pc_load) begin
      next_pc = tgt_aligned;
    end else if (redir_pend_q) begin
      next_pc = redir_tgt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      pc_q          <= RESET_VECTOR;
      redir_tgt_q   <= '0;
      redir_pend_q  <= 1'b0;
      instr_out_q   <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      instr_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (fetch_req && (pc_q == HALT_ADDR)) begin
            state_q  <= StHalt;
            halted_q <= 1'b1;
          end else begin
            if (fetch_req) begin
              state_q <= StRead;
            end
            if (pc_load) begin
              pc_q <= tgt_aligned;
            end
          end
        end
        StRead: begin
          if (pc_load) begin
            redir_pend_q <= 1'b1;
            redir_tgt_q  <= tgt_aligned;
          end
          if (!avm_waitrequest) begin
            instr_out_q   <= avm_readdata;
            instr_pc_q    <= pc_q;
            instr_valid_q <= 1'b1;
            pc_q          <= next_pc;
            redir_pend_q  <= 1'b0;
            state_q       <= StIdle;
          end
        end
        StHalt: begin
          halted_q <= 1'b1;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign avm_read    = (state_q == StRead);
  assign avm_address = pc_q & 32'hFFFF_FFFC;
  assign delay_out   = avm_read & avm_waitrequest;
  assign instr_out   = instr_out_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomised bench for instr_fetch_unit against a transaction-level PC/redirect model.
module tb_instr_fetch_unit;

  localparam logic [31:0] ResetVector = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        fetch_req = 1'b0;
  logic        pc_load = 1'b0;
  logic [31:0] pc_target = '0;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_waitrequest = 1'b0;
  logic [31:0] avm_readdata = '0;
  logic [31:0] instr_out;
  logic        instr_valid;
  logic [31:0] instr_pc;
  logic        delay_out;
  logic        halted;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model: next address to be fetched.
  logic [31:0] m_pc;

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .fetch_req       (fetch_req),
    .pc_load         (pc_load),
    .pc_target       (pc_target),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_waitrequest (avm_waitrequest),
    .avm_readdata    (avm_readdata),
    .instr_out       (instr_out),
    .instr_valid     (instr_valid),
    .instr_pc        (instr_pc),
    .delay_out       (delay_out),
    .halted          (halted)
  );

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    fetch_req = 1'b0;
    pc_load = 1'b0;
    avm_waitrequest = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    m_pc = ResetVector;
    n_checks++;
    if ({avm_read, instr_valid, halted, delay_out} !== 4'b0000) begin
      n_errors++;
      $display("FAIL reset_ctrl: got read/valid/halted/delay=%b, want 0000",
               {avm_read, instr_valid, halted, delay_out});
    end
    n_checks++;
    if (instr_out !== 32'h0 || instr_pc !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_regs: got instr_out=%h instr_pc=%h, want 0/0", instr_out, instr_pc);
    end
    n_checks++;
    if (avm_address !== ResetVector) begin
      n_errors++;
      $display("FAIL reset_pc: got %h, want %h", avm_address, ResetVector);
    end
  endtask

  // One fetch: IDLE cycle with fetch_req, then `waits` stalled cycles and a completion cycle.
  // Optionally a redirect on read cycle `ldcyc` (0..waits). Ends in the valid cycle.
  task automatic test_fetch(input int waits, input logic [31:0] data, input bit ld,
                            input int ldcyc, input logic [31:0] tgt);
    logic [31:0] exp_addr;
    exp_addr = m_pc;
    @(negedge clk);
    fetch_req = 1'b1;
    pc_load = 1'b0;
    #1;
    n_checks++;
    if (avm_read !== 1'b0) begin
      n_errors++;
      $display("FAIL idle_read: got avm_read=%b, want 0", avm_read);
    end
    if (exp_addr == 32'h0) begin
      @(negedge clk);
      fetch_req = 1'b0;
      #1;
      n_checks++;
      if (avm_read !== 1'b0 || halted !== 1'b1) begin
        n_errors++;
        $display("FAIL halt_entry: got read=%b halted=%b, want 0/1", avm_read, halted);
      end
      return;
    end
    for (int k = 0; k <= waits; k++) begin
      @(negedge clk);
      fetch_req = 1'b1;  // ignored while reading
      avm_waitrequest = (k < waits);
      avm_readdata = (k < waits) ? $urandom : data;
      pc_load = ld && (k == ldcyc);
      pc_target = tgt;
      #1;
      n_checks++;
      if (avm_read !== 1'b1 || avm_address !== exp_addr || delay_out !== (k < waits) ||
          instr_valid !== 1'b0) begin
        n_errors++;
        $display("FAIL read_cycle%0d: got read=%b addr=%h delay=%b valid=%b, want 1 %h %b 0",
                 k, avm_read, avm_address, delay_out, instr_valid, exp_addr, k < waits);
      end
    end
    @(negedge clk);
    fetch_req = 1'b0;
    pc_load = 1'b0;
    avm_waitrequest = 1'b0;
    #1;
    m_pc = ld ? (tgt & 32'hFFFF_FFFC) : m_pc + 32'd4;
    n_checks++;
    if (instr_valid !== 1'b1 || instr_out !== data || instr_pc !== exp_addr ||
        avm_read !== 1'b0) begin
      n_errors++;
      $display("FAIL deliver: got valid=%b out=%h pc=%h read=%b, want 1 %h %h 0",
               instr_valid, instr_out, instr_pc, avm_read, data, exp_addr);
    end
    n_checks++;
    if (avm_address !== m_pc) begin
      n_errors++;
      $display("FAIL next_pc: got %h, want %h", avm_address, m_pc);
    end
  endtask

  // Redirect while IDLE goes straight into the PC.
  task automatic test_idle_load(input logic [31:0] tgt);
    @(negedge clk);
    fetch_req = 1'b0;
    pc_load = 1'b1;
    pc_target = tgt;
    @(negedge clk);
    pc_load = 1'b0;
    #1;
    m_pc = tgt & 32'hFFFF_FFFC;
    n_checks++;
    if (avm_read !== 1'b0 || avm_address !== m_pc || instr_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL idle_load: got read=%b addr=%h valid=%b, want 0 %h 0",
               avm_read, avm_address, instr_valid, m_pc);
    end
  endtask

  task automatic test_halt_sticky();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      fetch_req = 1'b1;
      pc_load = $urandom_range(0, 1);
      pc_target = $urandom;
      #1;
      n_checks++;
      if (avm_read !== 1'b0 || halted !== 1'b1 || instr_valid !== 1'b0) begin
        n_errors++;
        $display("FAIL halt_sticky%0d: got read=%b halted=%b valid=%b, want 0 1 0",
                 i, avm_read, halted, instr_valid);
      end
    end
    fetch_req = 1'b0;
    pc_load = 1'b0;
  endtask

  task automatic test_reset_mid_read();
    @(negedge clk);
    fetch_req = 1'b1;
    @(negedge clk);
    fetch_req = 1'b0;
    avm_waitrequest = 1'b1;
    avm_readdata = 32'hDEAD_BEEF;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    avm_waitrequest = 1'b0;
    #1;
    m_pc = ResetVector;
    n_checks++;
    if (avm_read !== 1'b0 || instr_valid !== 1'b0 || avm_address !== ResetVector) begin
      n_errors++;
      $display("FAIL reset_mid_read: got read=%b valid=%b addr=%h, want 0 0 %h",
               avm_read, instr_valid, avm_address, ResetVector);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (instr_valid !== 1'b0 || avm_read !== 1'b0) begin
      n_errors++;
      $display("FAIL abandoned_data: got valid=%b read=%b, want 0 0", instr_valid, avm_read);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      int w;
      bit ld;
      w = $urandom_range(0, 3);
      ld = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) test_idle_load(32'h8000_0000 | $urandom);
      test_fetch(w, $urandom, ld, $urandom_range(0, w), 32'h8000_0000 | $urandom);
    end
  endtask

  initial begin
    test_reset();
    test_fetch(0, 32'h2402_0005, 1'b0, 0, 32'h0);
    test_fetch(3, 32'h1111_2222, 1'b1, 1, 32'hBFC0_0100);
    test_fetch(1, 32'h3333_4444, 1'b1, 1, 32'h1234_567B);  // redirect at completion, unaligned
    test_random();
    test_reset_mid_read();
    test_fetch(2, 32'h5555_6666, 1'b0, 0, 32'h0);
    test_fetch(2, 32'h7777_8888, 1'b1, 0, 32'h0);  // delay slot then halt
    test_fetch(0, 32'h0, 1'b0, 0, 32'h0);
    test_halt_sticky();
    test_reset();
    test_idle_load(32'hFFFF_FFFC);
    test_fetch(1, 32'h9999_AAAA, 1'b0, 0, 32'h0);  // wraps to 0
    test_fetch(0, 32'h0, 1'b0, 0, 32'h0);
    test_halt_sticky();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
